// File: rtl/scale_line_reader.sv
// Line reader: pulls one LINE_LEN-word line from an async FIFO read port
// (1-clk read latency) into a 2-entry skid buffer and streams it downstream.
module scale_line_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LINE_LEN   = 1024,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] LineLen = CNT_WIDTH'(LINE_LEN);
  localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(LINE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  issued_cnt_q, issued_cnt_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] hold_q [2];
  logic [DATA_WIDTH-1:0] hold_d [2];
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic pop;
  logic start_line;
  logic abort_rd;
  logic fill_ok;
  logic wr_idx;

  // State register.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRead;
      StRead: begin
        if (abort)               state_d = StIdle;
        else if (pop && m_last)  state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs and the stream/read-strobe decode.
  always_comb begin
    busy       = (state_q == StRead);
    done       = (state_q == StDone);
    m_valid    = (occ_q != 2'd0);
    m_data     = hold_q[0];
    pop        = m_valid & m_ready;
    m_last     = m_valid & (out_cnt_q == LastIdx);
    start_line = (state_q == StIdle) & start;
    abort_rd   = busy & abort;
    // Space check: entries held plus in flight, minus the one leaving now.
    fill_ok    = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    // abort also blocks the read so no FIFO word is consumed and then dropped.
    fifo_rd_en = busy & ~abort & ~fifo_rd_empty & (issued_cnt_q < LineLen) & fill_ok;
    stall_cnt  = stall_cnt_q;
  end

  // Counters, skid buffer and starvation counter next-state.
  always_comb begin
    issued_cnt_d = issued_cnt_q;
    out_cnt_d    = out_cnt_q;
    occ_d        = occ_q;
    inflight_d   = fifo_rd_en;
    hold_d[0]    = hold_q[0];
    hold_d[1]    = hold_q[1];
    stall_cnt_d  = stall_cnt_q;
    // Slot for the arriving word is occ-pop; occ==2 with a fill cannot occur.
    wr_idx       = occ_q[0] ^ pop;

    if (start_line) begin
      issued_cnt_d = '0;
      out_cnt_d    = '0;
    end else begin
      if (fifo_rd_en)   issued_cnt_d = issued_cnt_q + 1'b1;
      if (busy && pop)  out_cnt_d    = out_cnt_q + 1'b1;
    end

    if (abort_rd) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (pop)        hold_d[0]      = hold_q[1];
      if (inflight_q) hold_d[wr_idx] = fifo_rd_data;
      occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    if (busy && !m_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Datapath registers; reset discards buffered and in-flight data.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      issued_cnt_q <= '0;
      out_cnt_q    <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      hold_q[0]    <= '0;
      hold_q[1]    <= '0;
      stall_cnt_q  <= 16'd0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      out_cnt_q    <= out_cnt_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      hold_q[0]    <= hold_d[0];
      hold_q[1]    <= hold_d[1];
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_scale_line_reader.sv
// Scoreboard bench for scale_line_reader with LINE_LEN=8 and a 1-clk-latency FIFO model.
module tb_scale_line_reader;

  logic        clk = 1'b0;
  logic        tb_rst, start, abort;
  logic        fifo_rd_en, fifo_rd_empty;
  logic [15:0] fifo_rd_data = 16'h0;
  logic        m_valid, m_ready, m_last, busy, done;
  logic [15:0] m_data, stall_cnt;

  always #5 clk = ~clk;

  scale_line_reader #(
    .DATA_WIDTH(16),
    .LINE_LEN  (8),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .tb_rst       (tb_rst),
    .start        (start),
    .abort        (abort),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .stall_cnt    (stall_cnt)
  );

  // FIFO model: data appears the clock after the read strobe.
  logic [15:0] fifo_q[$];
  bit          force_empty = 1'b0;
  assign fifo_rd_empty = force_empty || (fifo_q.size() == 0);
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
  end

  int          checks = 0, failures = 0;
  int          cyc = 0, rd_cnt = 0, done_cnt = 0, last_acc_cyc = -10;
  bit          chk_stable = 1'b1;
  logic [16:0] exp_q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!tb_rst) begin
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got data=%h last=%b", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            failures++;
            $display("FAIL word got data=%h last=%b exp data=%h last=%b",
                     m_data, m_last, e[15:0], e[16]);
          end
        end
        if (m_last) last_acc_cyc = cyc;
      end
      if (fifo_rd_empty) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL rd_while_empty got=%b exp=0", fifo_rd_en);
        end
      end
      if (fifo_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        checks++;
        if (cyc != last_acc_cyc + 1) begin
          failures++;
          $display("FAIL done_timing got_cyc=%0d exp_cyc=%0d", cyc, last_acc_cyc + 1);
        end
      end
      if (chk_stable && pv && !pr) begin
        checks++;
        if (!m_valid || m_data !== pd) begin
          failures++;
          $display("FAIL stall_stable got v=%b d=%h exp v=1 d=%h", m_valid, m_data, pd);
        end
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Pulse start for one cycle; c0 is the cycle number in which start is driven.
  task automatic start_pulse(output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string name);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      k++;
    end
    checks++;
    if (done_cnt == n0) begin
      failures++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0, r0, d0;
    logic [15:0] s0;
    tb_rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    @(negedge clk);
    tb_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_auto_start", 32'(busy), 0);

    // Full-rate line: start sampled at edge 1, reads from cycle 1, words in cycles 3..10.
    for (int i = 0; i < 16; i++) fifo_q.push_back(16'hFFFF - 16'(i));
    for (int i = 0; i < 8; i++) expect_word(16'hFFFF - 16'(i), i == 7);
    m_ready = 1'b1;
    r0 = rd_cnt; s0 = stall_cnt;
    start_pulse(c0);
    wait_done(40, 1'b0, "line_full");
    chk("full_last_cycle", 32'(last_acc_cyc - c0), 10);
    chk("full_rd_pulses", 32'(rd_cnt - r0), 8);
    chk("full_stall", 32'(stall_cnt - s0), 2);
    chk("full_drain", 32'(exp_q.size()), 0);

    // Backpressure: m_ready toggles every cycle.
    for (int i = 8; i < 16; i++) expect_word(16'hFFFF - 16'(i), i == 15);
    m_ready = 1'b1;
    r0 = rd_cnt;
    start_pulse(c0);
    wait_done(80, 1'b1, "line_toggle");
    m_ready = 1'b1;
    chk("toggle_rd_pulses", 32'(rd_cnt - r0), 8);
    chk("toggle_drain", 32'(exp_q.size()), 0);

    // FIFO empty during cycles 5..9: 2 startup + 5 starved stall cycles.
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(16'h1000 + 16'(i));
      expect_word(16'h1000 + 16'(i), i == 7);
    end
    s0 = stall_cnt;
    start_pulse(c0);
    repeat (4) @(posedge clk);
    #1 force_empty = 1'b1;
    repeat (5) @(posedge clk);
    #1 force_empty = 1'b0;
    wait_done(60, 1'b0, "line_empty");
    chk("empty_stall", 32'(stall_cnt - s0), 7);
    chk("empty_drain", 32'(exp_q.size()), 0);

    // Abort after 3 accepted words; B3 buffered and B4 in flight are dropped.
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'h2000 + 16'(i));
    for (int i = 0; i < 3; i++) expect_word(16'h2000 + 16'(i), 1'b0);
    d0 = done_cnt;
    start_pulse(c0);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1; m_ready = 1'b0; chk_stable = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_m_valid", 32'(m_valid), 0);
    chk("abort_fifo_left", 32'(fifo_q.size()), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_drain", 32'(exp_q.size()), 0);
    m_ready = 1'b1;
    @(posedge clk); #1 chk_stable = 1'b1;
    for (int i = 0; i < 5; i++) fifo_q.push_back(16'h2100 + 16'(i));
    for (int i = 5; i < 8; i++) expect_word(16'h2000 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) expect_word(16'h2100 + 16'(i), i == 4);
    r0 = rd_cnt;
    start_pulse(c0);
    wait_done(40, 1'b0, "line_after_abort");
    chk("after_abort_rd", 32'(rd_cnt - r0), 8);

    // start while busy is ignored; start+abort together in IDLE still starts.
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(16'h3000 + 16'(i));
      expect_word(16'h3000 + 16'(i), i == 7);
    end
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'h3100 + 16'(i));
    start_pulse(c0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(40, 1'b0, "line_restart");
    repeat (4) @(posedge clk);
    #1;
    chk("restart_idle", 32'(busy), 0);
    chk("restart_fifo_left", 32'(fifo_q.size()), 8);
    for (int i = 0; i < 8; i++) expect_word(16'h3100 + 16'(i), i == 7);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 1);
    wait_done(40, 1'b0, "line_start_abort");
    chk("start_abort_drain", 32'(exp_q.size()), 0);

    // Async reset with the buffer full.
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'h4000 + 16'(i));
    m_ready = 1'b0; chk_stable = 1'b0;
    start_pulse(c0);
    repeat (4) @(posedge clk);
    #1;
    chk("full_buf_reads", 32'(fifo_q.size()), 2);
    chk("full_buf_valid", 32'(m_valid), 1);
    #2 tb_rst = 1'b1;
    #1;
    chk("async_m_valid", 32'(m_valid), 0);
    chk("async_m_data", 32'(m_data), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_rd_en", 32'(fifo_rd_en), 0);
    chk("async_stall", 32'(stall_cnt), 0);
    @(negedge clk);
    tb_rst = 1'b0;
    r0 = rd_cnt;
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_valid", 32'(m_valid), 0);
    chk("post_rst_no_rd", 32'(rd_cnt - r0), 0);
    fifo_q.delete();
    chk("scoreboard_drain", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
